// File: rtl/req_pkg.sv
// Shared constants and index type for the request conditioning stage.
package req_pkg;
    localparam int N_REQ_DEF      = 8;
    localparam int IDX_W          = 3;
    localparam int DEB_CYCLES_DEF = 4;

    typedef logic [IDX_W-1:0] req_idx_t;
endpackage

// File: rtl/req_deb_bit.sv
// One request line: 2-flop synchroniser followed by a counting debouncer.
module req_deb_bit #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [1:0]       sync_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             stable_next;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        stable_next = stable_reg;
        cnt_next    = '0;
        // Toggle on the sample that would bring the count to DEB_CYCLES.
        if (sync_reg[1] != stable_reg) begin
            if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
                stable_next = ~stable_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg   <= '0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync_reg   <= {sync_reg[0], din};
            stable_reg <= stable_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign stable = stable_reg;
endmodule

// File: rtl/req_pending_latch.sv
// Debounced rising edges become sticky pending bits cleared by indexed ack.
// Optional REQ_OVERRUN_EN adds an overrun flag per line.
module req_pending_latch
    import req_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_in,
    input  logic             ack,
    input  req_idx_t         ack_idx,
    output logic [N_REQ-1:0] pend,
    output logic             any_pend,
`ifdef REQ_OVERRUN_EN
    output logic [N_REQ-1:0] overrun,
`endif
    output logic [N_REQ-1:0] stable
);
    logic [N_REQ-1:0] stable_d_reg;
    logic [N_REQ-1:0] pend_reg;
    logic [N_REQ-1:0] pend_next;
    logic             any_pend_reg;
    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] clr;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_bit
            req_deb_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk    (clk),
                .rst    (rst),
                .din    (req_in[gi]),
                .stable (stable[gi])
            );
            assign rise[gi] = stable[gi] & ~stable_d_reg[gi];
            // Indices at or above N_REQ never match any bit, so they are ignored.
            assign clr[gi]  = ack && (ack_idx == IDX_W'(gi));
            // Set wins over a coincident clear so the new event is kept.
            assign pend_next[gi] = rise[gi] | (pend_reg[gi] & ~clr[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d_reg <= '0;
            pend_reg     <= '0;
            any_pend_reg <= 1'b0;
        end else begin
            stable_d_reg <= stable;
            pend_reg     <= pend_next;
            any_pend_reg <= |pend_next;
        end
    end

    assign pend     = pend_reg;
    assign any_pend = any_pend_reg;

`ifdef REQ_OVERRUN_EN
    logic [N_REQ-1:0] overrun_reg;
    logic [N_REQ-1:0] overrun_next;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ovr
            assign overrun_next[gi] =
                (rise[gi] & pend_reg[gi] & ~clr[gi]) |
                (overrun_reg[gi] & ~(clr[gi] & ~rise[gi]));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_reg <= '0;
        end else begin
            overrun_reg <= overrun_next;
        end
    end

    assign overrun = overrun_reg;
`endif
endmodule

// File: tb/tb_req_pending_latch.sv
// Directed bench for req_pending_latch; overrun checks run when REQ_OVERRUN_EN is defined.
module tb_req_pending_latch;
    import req_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_in;
    logic       ack;
    req_idx_t   ack_idx;
    logic [7:0] pend;
    logic       any_pend;
    logic [7:0] stable;
`ifdef REQ_OVERRUN_EN
    logic [7:0] overrun;
`endif

    int total = 0;
    int bad   = 0;

    req_pending_latch #(.N_REQ(8), .DEB_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .ack      (ack),
        .ack_idx  (ack_idx),
        .pend     (pend),
        .any_pend (any_pend),
`ifdef REQ_OVERRUN_EN
        .overrun  (overrun),
`endif
        .stable   (stable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_ack(input logic [2:0] idx);
        ack     = 1'b1;
        ack_idx = idx;
        step(1);
        ack     = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        req_in  = '0;
        ack     = 1'b0;
        ack_idx = '0;
        step(2);
        chk("reset_pend", pend, 8'h00);
        chk("reset_any", any_pend, 1'b0);
        chk("reset_stable", stable, 8'h00);
        rst = 1'b0;
        step(1);

        // Clean press on bit 5: stable after 6 edges, pend after 7.
        req_in = 8'h20;
        step(6);
        chk("press_stable_e6", stable, 8'h20);
        chk("press_pend_e6", pend, 8'h00);
        step(1);
        chk("press_pend_e7", pend, 8'h20);
        chk("press_any_e7", any_pend, 1'b1);
        req_in = 8'h00;
        step(8);
        chk("release_stable", stable, 8'h00);
        chk("release_pend", pend, 8'h20);
        do_ack(3'd5);
        chk("ack5_pend", pend, 8'h00);
        chk("ack5_any", any_pend, 1'b0);

        // Three-sample glitch on bit 2 is rejected.
        req_in = 8'h04;
        step(3);
        req_in = 8'h00;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("glitch_stable", stable, 8'h00);
            chk("glitch_pend", pend, 8'h00);
        end

        // Multi-request, acknowledged highest first.
        req_in = 8'h92;
        step(7);
        chk("multi_pend", pend, 8'h92);
        req_in = 8'h00;
        step(8);
        do_ack(3'd7);
        chk("ack7_pend", pend, 8'h12);
        do_ack(3'd4);
        chk("ack4_pend", pend, 8'h02);
        do_ack(3'd4);
        chk("ack4_again_noop", pend, 8'h02);
        do_ack(3'd1);
        chk("ack1_pend", pend, 8'h00);
        chk("ack1_any", any_pend, 1'b0);

        // Set/clear collision on bit 3: set wins.
        req_in = 8'h08;
        step(7);
        chk("coll_first_pend", pend, 8'h08);
        req_in = 8'h00;
        step(8);
        req_in = 8'h08;
        step(6);
        chk("coll_rise_stable", stable, 8'h08);
        do_ack(3'd3);
        chk("coll_pend_kept", pend, 8'h08);
`ifdef REQ_OVERRUN_EN
        chk("coll_overrun", overrun, 8'h00);
`endif
        req_in = 8'h00;
        step(8);
        do_ack(3'd3);
        chk("coll_cleanup", pend, 8'h00);

`ifdef REQ_OVERRUN_EN
        // Second press on pending bit 6 raises overrun; ack clears both.
        req_in = 8'h40;
        step(7);
        req_in = 8'h00;
        step(8);
        chk("ovr_pre", overrun, 8'h00);
        req_in = 8'h40;
        step(7);
        chk("ovr_set", overrun, 8'h40);
        chk("ovr_pend", pend, 8'h40);
        do_ack(3'd6);
        chk("ovr_ack_pend", pend, 8'h00);
        chk("ovr_ack_overrun", overrun, 8'h00);
        req_in = 8'h00;
        step(8);
`endif

        // Async reset mid-debounce with pend = 0x81.
        req_in = 8'h81;
        step(7);
        chk("prerst_pend", pend, 8'h81);
        req_in = 8'h01;
        step(3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pend", pend, 8'h00);
        chk("arst_any", any_pend, 1'b0);
        chk("arst_stable", stable, 8'h00);
`ifdef REQ_OVERRUN_EN
        chk("arst_overrun", overrun, 8'h00);
`endif
        rst = 1'b0;
        step(6);
        chk("postrst_pend_e6", pend, 8'h00);
        step(1);
        chk("postrst_pend_e7", pend, 8'h01);
        chk("postrst_any_e7", any_pend, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/req_pending_latch.md
# req_pending_latch

Input-conditioning stage placed directly upstream of the 8-to-3 highest-index priority encoder. It synchronises and debounces eight raw asynchronous request lines (buttons/switches). It turns each debounced rising edge into a sticky pending bit and holds that bit until the downstream consumer acknowledges it by index. `pend` drives the encoder input; the encoder's index output is fed back here as `ack_idx`.

## Interface
- `N_REQ`, 8: number of request lines; the index width is fixed at 3 for N_REQ = 8.
- `DEB_CYCLES`, 4: consecutive synchronised samples required to accept a level change; legal range ≥ 1.
- `clk` input 1: single system clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_in` input N_REQ: raw asynchronous request lines, active-high.
- `ack` input 1: acknowledge strobe, sampled on each rising edge.
- `ack_idx` input 3: index of the pending bit to clear when `ack` = 1.
- `pend` output N_REQ: sticky pending requests; connects to the encoder input.
- `any_pend` output 1: OR-reduction of `pend`, registered in the same cycle as `pend`.
- `stable` output N_REQ: current debounced level of each line (debug/LED).

## Operation
- Per bit: 2-flop synchroniser feeds a debouncer, which feeds a rising-edge detector and then the pending flop.
- **Debouncer:**
  - Holds the `stable` level and a counter of width clog2(DEB_CYCLES+1).
  - If sample == `stable`, the counter goes to 0.
  - Otherwise the counter increments.
  - When the counter would reach DEB_CYCLES, `stable` toggles and the counter returns to 0.
  - A glitch shorter than DEB_CYCLES samples never changes `stable`.
- **Edge detect:** `rise[i]` = `stable[i]` & ~`stable_d[i]`, where `stable_d` is a one-cycle-delayed copy of `stable`. Falling edges are ignored.
- **Pending set:** `rise[i]` sets `pend[i]`.
- **Pending clear:** `ack` clears `pend[ack_idx]`.
  - Only that one bit is cleared.
  - Ack of an already-clear bit is a no-op.
  - `ack_idx` ≥ N_REQ is ignored.
- **Simultaneous set and clear on the same bit in the same cycle:** set wins, so the new event is not lost.
- **Simultaneous set on bit j and clear on bit i ≠ j:** both take effect.
- **Rise while already pending:** the bit stays 1; there is no count. See Configuration for overrun reporting.
- **Reset:** all synchroniser flops, `stable`, `stable_d`, counters, `pend`, `any_pend` and `overrun` go to 0 immediately.
- **Reset mid-debounce:** the partial count is discarded.
- **Line held high through reset release:** it is debounced again from `stable` = 0 and produces one fresh pending event.

## Timing
- Raw line settles high before rising edge E0:
  - `stable[i]` = 1 after edge E0+DEB_CYCLES+1.
  - `pend[i]` and `any_pend` = 1 after edge E0+DEB_CYCLES+2.
  - Total: DEB_CYCLES+3 edges, which is 7 edges for the default of 4.
- Release of a line follows the same debounce latency on `stable`; `pend` is unaffected.
- Ack sampled at edge E: `pend[ack_idx]` = 0 and `any_pend` updated after edge E (one-cycle clear latency).
- The downstream encoder is combinational, so its index is valid in the same cycle `pend` changes.

## Configuration
- **Macro:** `REQ_OVERRUN_EN`.
- **Defined:**
  - Adds output `overrun` [N_REQ].
  - `overrun[i]` sets when `rise[i]` occurs while `pend[i]` is already 1 and not being cleared this cycle.
  - It clears when `ack` hits bit i with no coincident rise.
  - Reset value is 0.
- **Undefined:** the `overrun` port and its logic are absent; a rise on a pending bit is silently absorbed.

## Structure
- **Shared package `req_pkg`:**
  - `N_REQ_DEF` = 8.
  - `IDX_W` = 3.
  - `DEB_CYCLES_DEF` = 4.
  - Index type `req_idx_t` [IDX_W-1:0].
- **Sub-module `req_deb_bit`:** synchroniser plus debouncer for one line.
  - Ports: `clk`, `rst`, `din`, `stable`.
  - Instantiated N_REQ times via generate.
- The top level holds the edge detect, the pending/overrun registers and `any_pend`.

## Test plan
- **Clean press:** `req_in[5]` goes 0→1 and is held; with DEB_CYCLES = 4, `pend` = 0x20 and `any_pend` = 1 exactly 7 edges later; `pend` stays 0x20 after release.
- **Glitch rejection:** `req_in[2]` high for 3 cycles, then low → `stable` and `pend` remain 0x00 throughout.
- **Multi-request ack:** bits 1, 4 and 7 pending (`pend` = 0x92):
  - ack 7 → `pend` = 0x12;
  - ack 4 → `pend` = 0x02;
  - ack 1 → `pend` = 0x00 and `any_pend` = 0.
- **Set/clear collision:** `pend[3]` = 1; a second debounced rise on bit 3 coincides with `ack` = 1, `ack_idx` = 3 → `pend[3]` remains 1. With `REQ_OVERRUN_EN`, `overrun[3]` stays 0 because the clear coincides.
- **Overrun (macro defined):** bit 6 pending; press again before ack → `overrun` = 0x40; ack 6 → `pend[6]` = 0 and `overrun` = 0x00.
- **Async reset mid-operation:** assert `rst` between clock edges during a debounce with `pend` = 0x81 → all outputs 0 immediately. Release with `req_in[0]` held high → `pend` = 0x01 after DEB_CYCLES+3 edges.
